mu0_boot_arbiter: RTL and testbench
===================================

Name: mu0_boot_arbiter

Overview:
- Owns the single memory_32x16 port and shares it between a host loader and the MU0 core.
- Holds the core in reset while the host streams a program image into memory, then releases the core to run.
- When the core signals STOP, hands the memory back to the host for readback.
- Replaces force-based program loading with a real boot sequence.

Parameters:
DEPTH, 32, number of memory words; load address range is 0..DEPTH-1
RST_HOLD, 4, cycles core_rst_n stays low after the last load write
RD_LAT, 1, memory read latency in cycles (host readback path only)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
h_start  input  1  pulse: begin a load (accepted in IDLE and HALTED only)
h_valid  input  1  host load word valid
h_ready  output  1  arbiter accepts a load word this cycle
h_wdata  input  16  load word
h_last  input  1  marks the final load word (qualified by h_valid)
h_rd_req  input  1  host readback request (HALTED only)
h_rd_addr  input  12  readback address
h_rd_valid  output  1  one-cycle pulse: h_rd_data valid
h_rd_data  output  16  readback data
load_err  output  1  image overflowed DEPTH; sticky until next accepted h_start
state  output  3  IDLE=0, LOAD=1, RELEASE=2, RUN=3, HALTED=4
core_rst_n  output  1  reset to MU0, active low
core_memrq  input  1  MU0 memrq
core_rnw  input  1  MU0 rnw (1 = read)
core_addr  input  12  MU0 out_address
core_wdata  input  16  MU0 out_data
core_halt  input  1  MU0 has executed STOP
core_rdata  output  16  data to MU0 in_data
mem_memrq  output  1  to memory memrq
mem_rw  output  1  to memory rw (1 = read)
mem_addr  output  12  to memory addr
mem_wdata  output  16  to memory in_data
mem_rdata  input  16  from memory out_data

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, core_rst_n=0, h_ready=0, h_rd_valid=0, h_rd_data=0, load_err=0.
  - mem_memrq=0, mem_rw=1, mem_addr=0, mem_wdata=0.
  - Write pointer wptr=0, hold counter=0.
  - Reset mid-load aborts the load; memory contents already written are not cleared.
- IDLE:
  - core_rst_n=0, memory idle.
  - h_start -> LOAD next cycle: wptr:=0, load_err:=0.
- LOAD:
  - h_ready=1, core_rst_n=0.
  - A beat is h_valid & h_ready. On each beat: mem_memrq=1, mem_rw=0, mem_addr=wptr, mem_wdata=h_wdata in that same cycle (memory writes at that edge); then wptr++.
  - Beat with h_last=1 -> RELEASE; hold counter:=RST_HOLD.
  - Beat at wptr=DEPTH-1 with h_last=0: write performed, load_err:=1, state -> IDLE, core stays in reset.
  - No beat: mem_memrq=0. h_start is ignored.
- RELEASE:
  - h_ready=0, core_rst_n=0, memory idle.
  - Counter decrements each cycle. On the cycle it reaches 0 -> RUN and core_rst_n=1 from that cycle on.
  - Core is held in reset for exactly RST_HOLD cycles after the last write cycle.
- RUN:
  - Zero-latency combinational pass-through: mem_memrq=core_memrq, mem_rw=core_rnw, mem_addr=core_addr, mem_wdata=core_wdata, core_rdata=mem_rdata.
  - Host ports inactive; h_start and h_rd_req are ignored.
  - core_halt=1 sampled -> HALTED next cycle.
- HALTED:
  - core_rst_n stays 1, core port disconnected. mem_memrq is driven only by host reads.
  - h_rd_req with no read pending: mem_memrq=1, mem_rw=1, mem_addr=h_rd_addr that cycle.
  - RD_LAT cycles later: h_rd_valid=1 for one cycle and h_rd_data=mem_rdata.
  - Only one read is outstanding at a time; h_rd_req while a read is pending is dropped.
  - h_start -> LOAD: core_rst_n=0 in the next cycle. If h_start and h_rd_req arrive together, h_start wins, the read is not issued, and any pending h_rd_valid is suppressed.
- core_rdata=0 in every state except RUN.
- h_rd_addr >= DEPTH is passed to memory unchanged; the result is memory-defined.
- Write pointer width is clog2(DEPTH); it never wraps because overflow ends the load.

Test Plan:
- Load 17 words (JMP 5 .. STOP, last at addr 16) then 240 and 13 at 17/18, h_last on word 18 -> 19 writes at addrs 0..18; core_rst_n rises exactly 4 cycles after the last write; state=RUN.
- Full program run: after release, core executes the image to STOP -> core_halt, state=HALTED. Readback of addr 17 -> 13, addr 18 -> 26, each h_rd_valid exactly 1 cycle after h_rd_req.
- Overflow: 32 beats with h_last=0 -> load_err=1 after beat 32, state=IDLE, core_rst_n=0. Next h_start -> load_err=0.
- Gappy host: toggle h_valid every other cycle during LOAD -> writes only on valid cycles; addresses remain contiguous.
- Illegal requests: h_start and h_rd_req during RUN -> ignored, memory bus equals core bus bit-for-bit. In HALTED, h_start together with h_rd_req -> LOAD, no h_rd_valid.
- Async rst_n pulse mid-load at wptr=7 -> all outputs at reset values immediately. Reload of 3 words -> addrs 0..2 rewritten, addrs 3..6 keep the old data.

Source files
------------

// File: rtl/mu0_boot_arbiter.sv
// Boot arbiter for the single MU0 memory port: host streams an image in while
// the core is held in reset, the core runs, then the host reads results back.
module mu0_boot_arbiter #(
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned RST_HOLD = 4,
  parameter int unsigned RD_LAT   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        h_start,
  input  logic        h_valid,
  output logic        h_ready,
  input  logic [15:0] h_wdata,
  input  logic        h_last,
  input  logic        h_rd_req,
  input  logic [11:0] h_rd_addr,
  output logic        h_rd_valid,
  output logic [15:0] h_rd_data,
  output logic        load_err,
  output logic [2:0]  state,
  output logic        core_rst_n,
  input  logic        core_memrq,
  input  logic        core_rnw,
  input  logic [11:0] core_addr,
  input  logic [15:0] core_wdata,
  input  logic        core_halt,
  output logic [15:0] core_rdata,
  output logic        mem_memrq,
  output logic        mem_rw,
  output logic [11:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned HW = (RST_HOLD > 0) ? $clog2(RST_HOLD + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_RELEASE = 3'd2,
    S_RUN     = 3'd3,
    S_HALTED  = 3'd4
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [AW-1:0]     r_wptr, w_wptr_nxt;
  logic [HW-1:0]     r_hold, w_hold_nxt;
  logic              r_load_err, w_load_err_nxt;
  logic [RD_LAT-1:0] r_rd_pipe, w_rd_pipe_nxt;
  logic              w_wptr_end;

  assign w_wptr_end = (r_wptr == AW'(DEPTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_wptr     <= '0;
      r_hold     <= '0;
      r_load_err <= 1'b0;
      r_rd_pipe  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wptr     <= w_wptr_nxt;
      r_hold     <= w_hold_nxt;
      r_load_err <= w_load_err_nxt;
      r_rd_pipe  <= w_rd_pipe_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_wptr_nxt     = r_wptr;
    w_hold_nxt     = r_hold;
    w_load_err_nxt = r_load_err;
    w_rd_pipe_nxt  = r_rd_pipe << 1;
    h_ready        = 1'b0;
    mem_memrq      = 1'b0;
    mem_rw         = 1'b1;
    mem_addr       = '0;
    mem_wdata      = '0;
    core_rdata     = '0;

    case (r_state)
      S_IDLE: begin
        if (h_start) begin
          w_state_nxt    = S_LOAD;
          w_wptr_nxt     = '0;
          w_load_err_nxt = 1'b0;
        end
      end
      S_LOAD: begin
        h_ready = 1'b1;
        if (h_valid) begin
          mem_memrq = 1'b1;
          mem_rw    = 1'b0;
          mem_addr  = 12'(r_wptr);
          mem_wdata = h_wdata;
          // Saturate rather than wrap: the final slot always ends the load.
          if (!w_wptr_end) w_wptr_nxt = r_wptr + AW'(1);
          if (h_last) begin
            w_state_nxt = S_RELEASE;
            w_hold_nxt  = HW'(RST_HOLD);
          end else if (w_wptr_end) begin
            w_state_nxt    = S_IDLE;
            w_load_err_nxt = 1'b1;
          end
        end
      end
      S_RELEASE: begin
        if (r_hold <= HW'(1)) begin
          w_state_nxt = S_RUN;
          w_hold_nxt  = '0;
        end else begin
          w_hold_nxt = r_hold - HW'(1);
        end
      end
      S_RUN: begin
        mem_memrq  = core_memrq;
        mem_rw     = core_rnw;
        mem_addr   = core_addr;
        mem_wdata  = core_wdata;
        core_rdata = mem_rdata;
        if (core_halt) w_state_nxt = S_HALTED;
      end
      S_HALTED: begin
        if (h_start) begin
          w_state_nxt    = S_LOAD;
          w_wptr_nxt     = '0;
          w_load_err_nxt = 1'b0;
          w_rd_pipe_nxt  = '0;
        end else if (h_rd_req && !(|r_rd_pipe)) begin
          mem_memrq        = 1'b1;
          mem_rw           = 1'b1;
          mem_addr         = h_rd_addr;
          w_rd_pipe_nxt[0] = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign state      = r_state;
  assign core_rst_n = (r_state == S_RUN) || (r_state == S_HALTED);
  assign load_err   = r_load_err;
  assign h_rd_valid = r_rd_pipe[RD_LAT-1];
  assign h_rd_data  = h_rd_valid ? mem_rdata : '0;

endmodule

// File: tb/tb_mu0_boot_arbiter.sv
// Scoreboard bench for mu0_boot_arbiter with a behavioural memory and a small
// multi-cycle MU0 core model sharing the arbitrated port.
module tb_mu0_boot_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        h_start, h_valid, h_ready, h_last, h_rd_req, h_rd_valid;
  logic [15:0] h_wdata, h_rd_data;
  logic [11:0] h_rd_addr;
  logic        load_err, core_rst_n;
  logic [2:0]  state;
  logic        core_memrq, core_rnw, core_halt;
  logic [11:0] core_addr;
  logic [15:0] core_wdata, core_rdata;
  logic        mem_memrq, mem_rw;
  logic [11:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mu0_boot_arbiter #(.DEPTH(32), .RST_HOLD(4), .RD_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .h_start(h_start), .h_valid(h_valid),
    .h_ready(h_ready), .h_wdata(h_wdata), .h_last(h_last),
    .h_rd_req(h_rd_req), .h_rd_addr(h_rd_addr), .h_rd_valid(h_rd_valid),
    .h_rd_data(h_rd_data), .load_err(load_err), .state(state),
    .core_rst_n(core_rst_n), .core_memrq(core_memrq), .core_rnw(core_rnw),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_halt(core_halt),
    .core_rdata(core_rdata), .mem_memrq(mem_memrq), .mem_rw(mem_rw),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // memory: synchronous write, one-cycle registered read
  logic [15:0] mem [0:4095];
  always @(posedge clk) begin
    if (mem_memrq) begin
      if (mem_rw) mem_rdata <= mem[mem_addr];
      else        mem[mem_addr] <= mem_wdata;
    end
  end

  // MU0 model: fetch, decode, execute (issue operand access), writeback
  typedef enum logic [2:0] {C_F, C_D, C_X, C_W, C_H} cst_t;
  cst_t        cs;
  logic [11:0] pc;
  logic [15:0] ir, acc;
  logic [3:0]  op;
  assign op = ir[15:12];

  always @(posedge clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      cs <= C_F; pc <= '0; ir <= '0; acc <= '0;
    end else begin
      case (cs)
        C_F: cs <= C_D;
        C_D: begin ir <= core_rdata; cs <= C_X; end
        C_X: begin
          case (op)
            4'd0, 4'd2, 4'd3: cs <= C_W;
            4'd1: begin pc <= pc + 12'd1; cs <= C_F; end
            4'd4: begin pc <= ir[11:0]; cs <= C_F; end
            default: cs <= C_H;
          endcase
        end
        C_W: begin
          case (op)
            4'd0:    acc <= core_rdata;
            4'd2:    acc <= acc + core_rdata;
            default: acc <= acc - core_rdata;
          endcase
          pc <= pc + 12'd1;
          cs <= C_F;
        end
        default: cs <= C_H;
      endcase
    end
  end

  assign core_memrq = (cs == C_F) || ((cs == C_X) && (op <= 4'd3));
  assign core_rnw   = !((cs == C_X) && (op == 4'd1));
  assign core_addr  = (cs == C_F) ? pc : ir[11:0];
  assign core_wdata = acc;
  assign core_halt  = (cs == C_H);

  // scoreboard
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int exp_addr = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [11:0] a; logic [15:0] d; } wr_t;
  typedef struct { logic [15:0] d; int c; } rd_t;
  wr_t wq[$];
  rd_t rq[$];
  wr_t we;
  rd_t re;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_memrq && !mem_rw && state != 3'd3) begin
        n_tests++;
        if (wq.size() == 0) begin
          n_fail++;
          $display("FAIL wr_unexpected: got write addr %0d data %h, expected none", mem_addr, mem_wdata);
        end else begin
          we = wq.pop_front();
          n_tests--;
          chk("wr_addr", 32'(mem_addr), 32'(we.a));
          chk("wr_data", 32'(mem_wdata), 32'(we.d));
        end
      end
      if (h_rd_valid) begin
        n_tests++;
        if (rq.size() == 0) begin
          n_fail++;
          $display("FAIL rd_unexpected: got h_rd_valid data %h, expected none", h_rd_data);
        end else begin
          re = rq.pop_front();
          n_tests--;
          chk("rd_data", 32'(h_rd_data), 32'(re.d));
          chk("rd_cycle", 32'(cyc), 32'(re.c));
        end
      end
      if (state == 3'd3) begin
        chk("run_bus", {2'b0, mem_memrq, mem_rw, mem_addr, mem_wdata},
            {2'b0, core_memrq, core_rnw, core_addr, core_wdata});
        chk("run_rdata", 32'(core_rdata), 32'(mem_rdata));
      end else begin
        chk("rdata_idle", 32'(core_rdata), 32'h0);
      end
      if (state == 3'd1) chk("load_memrq", 32'(mem_memrq), 32'(h_valid));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start();
    h_start = 1'b1;
    tick();
    h_start  = 1'b0;
    exp_addr = 0;
  endtask

  task automatic beat(input logic [15:0] d, input logic last);
    h_valid = 1'b1; h_wdata = d; h_last = last;
    wq.push_back('{a: 12'(exp_addr), d: d});
    exp_addr++;
    tick();
    h_valid = 1'b0; h_last = 1'b0;
  endtask

  task automatic rd(input logic [11:0] a, input logic [15:0] d);
    h_rd_req = 1'b1; h_rd_addr = a;
    rq.push_back('{d: d, c: cyc + 1});
    tick();
    h_rd_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic wait_state(input logic [2:0] s, input string name);
    int k = 0;
    while (state !== s && k < 500) begin
      tick();
      k++;
    end
    chk(name, 32'(state), 32'(s));
  endtask

  logic [15:0] img [19] = '{16'h4005, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                            16'h0012, 16'h1011, 16'h2012, 16'h1012, 16'h4010,
                            16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                            16'h0000, 16'h7000, 16'd240,  16'd13};
  logic [15:0] gap [6] = '{16'h7000, 16'hA001, 16'hA002, 16'hA003, 16'hA004, 16'hA005};

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_state"}, 32'(state), 32'h0);
    chk({tag, "_core_rst_n"}, 32'(core_rst_n), 32'h0);
    chk({tag, "_h_ready"}, 32'(h_ready), 32'h0);
    chk({tag, "_h_rd_valid"}, 32'(h_rd_valid), 32'h0);
    chk({tag, "_h_rd_data"}, 32'(h_rd_data), 32'h0);
    chk({tag, "_load_err"}, 32'(load_err), 32'h0);
    chk({tag, "_mem_memrq"}, 32'(mem_memrq), 32'h0);
    chk({tag, "_mem_rw"}, 32'(mem_rw), 32'h1);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'h0);
    chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'h0);
  endtask

  initial begin
    h_start = 0; h_valid = 0; h_last = 0; h_rd_req = 0;
    h_wdata = '0; h_rd_addr = '0;
    #1 rst_n = 1'b0;
    #1 chk_reset_outputs("reset");
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("idle_state", 32'(state), 32'h0);

    // main image load; core held low for exactly 4 cycles after the last write
    start();
    chk("state_load", 32'(state), 32'h1);
    for (int i = 0; i < 19; i++) beat(img[i], (i == 18));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("hold_rst", 32'(core_rst_n), 32'h0);
    end
    @(negedge clk);
    chk("release_rst", 32'(core_rst_n), 32'h1);
    chk("state_run", 32'(state), 32'h3);

    // host requests during RUN are ignored
    tick();
    h_start = 1'b1; h_rd_req = 1'b1; h_rd_addr = 12'd17;
    tick();
    h_start = 1'b0; h_rd_req = 1'b0;
    @(negedge clk);
    chk("run_ignore_state", 32'(state), 32'h3);
    chk("run_ignore_rst", 32'(core_rst_n), 32'h1);
    tick();

    wait_state(3'd4, "halted_main");
    rd(12'd17, 16'd13);
    rd(12'd18, 16'd26);

    // start together with read: start wins, no read data
    h_start = 1'b1; h_rd_req = 1'b1; h_rd_addr = 12'd18;
    tick();
    h_start = 1'b0; h_rd_req = 1'b0; exp_addr = 0;
    chk("start_wins", 32'(state), 32'h1);
    chk("start_core_rst", 32'(core_rst_n), 32'h0);

    // gappy host, with an ignored h_start inside LOAD
    for (int i = 0; i < 6; i++) begin
      if (i == 2) h_start = 1'b1;
      tick();
      h_start = 1'b0;
      beat(gap[i], (i == 5));
    end
    wait_state(3'd4, "halted_gap");

    // overflow
    start();
    for (int i = 0; i < 32; i++) beat(16'hD000 + 16'(i), 1'b0);
    chk("ovf_err", 32'(load_err), 32'h1);
    chk("ovf_state", 32'(state), 32'h0);
    chk("ovf_core_rst", 32'(core_rst_n), 32'h0);
    start();
    chk("ovf_err_clear", 32'(load_err), 32'h0);
    chk("ovf_restart", 32'(state), 32'h1);

    // async reset mid-load at wptr=7
    for (int i = 0; i < 7; i++) beat(16'hB000 + 16'(i), 1'b0);
    h_valid = 1'b1; h_wdata = 16'hBEEF;
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("async");
    h_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    start();
    beat(16'h7000, 1'b0);
    beat(16'hC001, 1'b0);
    beat(16'hC002, 1'b1);
    for (int a = 3; a < 7; a++) chk("keep_old", 32'(mem[a]), 32'(16'hB000 + 16'(a)));
    wait_state(3'd4, "halted_reload");
    rd(12'd4, 16'hB004);
    rd(12'd1, 16'hC001);
    rd(12'd0, 16'h7000);

    chk("wq_drained", 32'(wq.size()), 32'h0);
    chk("rq_drained", 32'(rq.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
